// File: rtl/aes_mode_sequencer_pkg.sv
// Shared encodings for the AES block-mode sequencer: block width, mode codes
// and FSM state codes.
package aes_seq_pkg;

  localparam int BLK_W = 128;
  localparam int CTR_W = 64;

  typedef logic [BLK_W-1:0] blk_t;

  localparam logic [1:0] MODE_CFB  = 2'd0;
  localparam logic [1:0] MODE_OFB  = 2'd1;
  localparam logic [1:0] MODE_CTR  = 2'd2;
  localparam logic [1:0] MODE_RSVD = 2'd3;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_CORE = 3'd2;
  localparam logic [2:0] ST_OUT  = 3'd3;
  localparam logic [2:0] ST_FIN  = 3'd4;

endpackage

// File: rtl/aes_mode_sequencer_if.sv
// Plaintext/ciphertext streams and external AES core hookup for the sequencer.
// master = sequencer side, slave = environment (sources, sinks, core).
interface aes_mode_sequencer_if;
  import aes_seq_pkg::*;

  logic pt_valid;
  logic pt_ready;
  blk_t pt_data;
  logic ct_valid;
  logic ct_ready;
  blk_t ct_data;
  logic core_start;
  blk_t core_state;
  logic core_done;
  blk_t core_out;

  modport master (
    input  pt_valid, pt_data, ct_ready, core_done, core_out,
    output pt_ready, ct_valid, ct_data, core_start, core_state
  );

  modport slave (
    output pt_valid, pt_data, ct_ready, core_done, core_out,
    input  pt_ready, ct_valid, ct_data, core_start, core_state
  );

endinterface

// File: rtl/aes_mode_sequencer.sv
// CFB/OFB/CTR block sequencer around an external AES-256 core.
// AES_SEQ_CTR_EN: when defined, CTR mode is built in; otherwise mode 2 is rejected.
//
// state | meaning
// IDLE  | waiting for start; rejects bad mode, short-circuits nblocks=0
// LOAD  | pt_ready high, waiting for a plaintext block
// CORE  | core launched on core_state, waiting for core_done
// OUT   | ct_valid high, waiting for ct_ready
// FIN   | one-cycle done pulse, then back to IDLE
module aes_mode_sequencer
  import aes_seq_pkg::*;
#(
  parameter int NBLK_W = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_i,
  input  logic [1:0]           mode_i,
  input  logic [NBLK_W-1:0]    nblocks_i,
  input  blk_t                 iv_i,
  input  logic [CTR_W-1:0]     nonce_i,
  aes_mode_sequencer_if.master bus,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);

  logic [2:0]        state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [NBLK_W-1:0] nblk_q, nblk_d;
  blk_t              fb_q, fb_d;
  blk_t              pt_q, pt_d;
  blk_t              ct_q, ct_d;
  logic              core_start_q, core_start_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              mode_ok;

`ifdef AES_SEQ_CTR_EN
  logic [CTR_W-1:0]  ctr_q, ctr_d;
  assign mode_ok = (mode_i != MODE_RSVD);
`else
  logic unused_nonce;
  assign unused_nonce = ^nonce_i;
  assign mode_ok = (mode_i == MODE_CFB) || (mode_i == MODE_OFB);
`endif

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    nblk_d       = nblk_q;
    fb_d         = fb_q;
    pt_d         = pt_q;
    ct_d         = ct_q;
    core_start_d = 1'b0;
    done_d       = 1'b0;
    err_d        = 1'b0;
`ifdef AES_SEQ_CTR_EN
    ctr_d        = ctr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (!mode_ok) begin
            err_d = 1'b1;
          end else if (nblocks_i == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_LOAD;
            mode_d  = mode_i;
            nblk_d  = nblocks_i;
            fb_d    = iv_i;
`ifdef AES_SEQ_CTR_EN
            ctr_d   = '0;
            if (mode_i == MODE_CTR) fb_d = {nonce_i, {CTR_W{1'b0}}};
`endif
          end
        end
      end
      ST_LOAD: begin
        if (bus.pt_valid) begin
          pt_d         = bus.pt_data;
          core_start_d = 1'b1;
          state_d      = ST_CORE;
        end
      end
      ST_CORE: begin
        // core_state is only advanced here, so it stays put while the core works
        if (bus.core_done) begin
          ct_d    = pt_q ^ bus.core_out;
          state_d = ST_OUT;
          case (mode_q)
            MODE_CFB: fb_d = pt_q ^ bus.core_out;
            MODE_OFB: fb_d = bus.core_out;
`ifdef AES_SEQ_CTR_EN
            MODE_CTR: begin
              ctr_d = ctr_q + CTR_W'(1);
              fb_d  = {fb_q[BLK_W-1:CTR_W], ctr_q + CTR_W'(1)};
            end
`endif
            default: ;
          endcase
        end
      end
      ST_OUT: begin
        if (bus.ct_ready) begin
          if (nblk_q > NBLK_W'(1)) begin
            nblk_d  = nblk_q - NBLK_W'(1);
            state_d = ST_LOAD;
          end else begin
            nblk_d  = '0;
            done_d  = 1'b1;
            state_d = ST_FIN;
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_CFB;
      nblk_q       <= '0;
      fb_q         <= '0;
      pt_q         <= '0;
      ct_q         <= '0;
      core_start_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef AES_SEQ_CTR_EN
      ctr_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      nblk_q       <= nblk_d;
      fb_q         <= fb_d;
      pt_q         <= pt_d;
      ct_q         <= ct_d;
      core_start_q <= core_start_d;
      done_q       <= done_d;
      err_q        <= err_d;
`ifdef AES_SEQ_CTR_EN
      ctr_q        <= ctr_d;
`endif
    end
  end

  assign bus.pt_ready   = (state_q == ST_LOAD);
  assign bus.ct_valid   = (state_q == ST_OUT);
  assign bus.ct_data    = ct_q;
  assign bus.core_start = core_start_q;
  assign bus.core_state = fb_q;
  assign busy_o         = (state_q != ST_IDLE);
  assign done_o         = done_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_aes_mode_sequencer.sv
// Scoreboard bench for aes_mode_sequencer with a 14-cycle stub core (out = ~state).
// Stimulus queues expected core_state/ct values; a negedge monitor pops and compares.
module tb_aes_mode_sequencer;
  import aes_seq_pkg::*;

  localparam int   NBLK_W   = 3;
  localparam int   CORE_LAT = 14;
  localparam blk_t ZERO     = '0;
  localparam blk_t ONES     = '1;
  localparam blk_t IV_A     = {4{32'h0000FFFF}};
  localparam blk_t PT_A0    = {4{32'h00FF00FF}};
  localparam blk_t CT_A0    = {4{32'hFF0000FF}};
  localparam blk_t PT_A1    = {4{32'h0F0F0F0F}};
  localparam blk_t CT_A1    = {4{32'h0FF0F00F}};
  localparam logic [63:0] NONCE = 64'hA5A5A5A5A5A5A5A5;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start_i = 1'b0;
  logic [1:0]        mode_i = 2'd0;
  logic [NBLK_W-1:0] nblocks_i = '0;
  blk_t              iv_i = '0;
  logic [63:0]       nonce_i = '0;
  logic              busy_o, done_o, err_o;

  aes_mode_sequencer_if bus();

  aes_mode_sequencer #(.NBLK_W(NBLK_W)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .mode_i(mode_i),
    .nblocks_i(nblocks_i), .iv_i(iv_i), .nonce_i(nonce_i), .bus(bus),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  blk_t stub_st;
  int   stub_lat;
  logic stub_busy;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.core_done <= 1'b0;
      bus.core_out  <= '0;
      stub_st       <= '0;
      stub_lat      <= 0;
      stub_busy     <= 1'b0;
    end else begin
      bus.core_done <= 1'b0;
      if (bus.core_start) begin
        stub_st   <= bus.core_state;
        stub_lat  <= CORE_LAT - 2;
        stub_busy <= 1'b1;
      end else if (stub_busy) begin
        if (stub_lat == 0) begin
          bus.core_done <= 1'b1;
          bus.core_out  <= ~stub_st;
          stub_busy     <= 1'b0;
        end else begin
          stub_lat <= stub_lat - 1;
        end
      end
    end
  end

  int   n_pass = 0, n_total = 0;
  int   done_cnt = 0, err_cnt = 0, cs_cnt = 0;
  int   exp_done = 0, exp_err = 0, exp_cs_cnt = 0;
  blk_t exp_ct[$];
  blk_t exp_cs[$];
  blk_t pts[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", nm, act, exp);
  endtask

  task automatic fail_to(input string nm);
    n_total++;
    $display("FAIL %s: got no event within bound, required the event", nm);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (done_o) done_cnt++;
      if (err_o) err_cnt++;
      if (bus.core_start) begin
        cs_cnt++;
        if (exp_cs.size() == 0) begin
          n_total++;
          $display("FAIL core_state: got unexpected core_start state %h required none", bus.core_state);
        end else chk("core_state", bus.core_state, exp_cs.pop_front());
      end
      if (bus.ct_valid && bus.ct_ready) begin
        if (exp_ct.size() == 0) begin
          n_total++;
          $display("FAIL ct_data: got unexpected ct %h required none", bus.ct_data);
        end else chk("ct_data", bus.ct_data, exp_ct.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] m, input int n, input blk_t iv, input logic [63:0] nonce);
    mode_i    = m;
    nblocks_i = NBLK_W'(n);
    iv_i      = iv;
    nonce_i   = nonce;
    start_i   = 1'b1;
    tick();
    start_i   = 1'b0;
  endtask

  task automatic feed(input blk_t d);
    bit got = 0;
    bus.pt_data  = d;
    bus.pt_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.pt_ready) begin got = 1; break; end
    end
    if (!got) fail_to("pt_handshake");
    tick();
    bus.pt_valid = 1'b0;
  endtask

  task automatic hold_seq();
    bit got = 0;
    bus.ct_ready = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.ct_valid) begin got = 1; break; end
    end
    if (!got) fail_to("ct_valid_wait");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_valid", bus.ct_valid, 1'b1);
      chk("hold_data", bus.ct_data, ONES);
      chk("hold_no_core_start", cs_cnt, exp_cs_cnt + 1);
    end
    tick();
    bus.ct_ready = 1'b1;
  endtask

  task automatic run_job(input logic [1:0] m, input int n, input blk_t iv, input logic [63:0] nonce,
                         input bit hold, input bit poke);
    bit got = 0;
    issue(m, n, iv, nonce);
    for (int b = 0; b < n; b++) begin
      feed(pts[b]);
      if (b == 0 && poke) begin
        mode_i = MODE_OFB; nblocks_i = NBLK_W'(5); iv_i = ONES; start_i = 1'b1;
        tick();
        start_i = 1'b0;
      end
      if (b == 0 && hold) hold_seq();
    end
    exp_done++;
    exp_cs_cnt += n;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done_cnt >= exp_done) begin got = 1; break; end
    end
    if (!got) fail_to("job_done");
    repeat (3) tick();
    chk("job_done_count", done_cnt, exp_done);
    chk("job_core_starts", cs_cnt, exp_cs_cnt);
    chk("job_busy_after", busy_o, 1'b0);
    chk("job_ct_left", exp_ct.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.pt_valid = 1'b0;
    bus.pt_data  = '0;
    bus.ct_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_pt_ready", bus.pt_ready, 1'b0);
    chk("rst_ct_valid", bus.ct_valid, 1'b0);
    chk("rst_core_start", bus.core_start, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_ct_data", bus.ct_data, ZERO);
    chk("rst_core_state", bus.core_state, ZERO);
    reset = 1'b0;
    repeat (2) tick();

    // CFB, zero iv and plaintext
    exp_cs.push_back(ZERO); exp_cs.push_back(ONES);
    exp_ct.push_back(ONES); exp_ct.push_back(ZERO);
    pts = {ZERO, ZERO};
    run_job(MODE_CFB, 2, ZERO, 64'd0, 1'b0, 1'b0);

    // CFB, mixed pattern, with a start poked mid-job
    exp_cs.push_back(IV_A);  exp_cs.push_back(CT_A0);
    exp_ct.push_back(CT_A0); exp_ct.push_back(CT_A1);
    pts = {PT_A0, PT_A1};
    run_job(MODE_CFB, 2, IV_A, 64'd0, 1'b0, 1'b1);

    // OFB, 3 blocks, ct_ready held low on the first
    exp_cs.push_back(ZERO); exp_cs.push_back(ONES); exp_cs.push_back(ZERO);
    exp_ct.push_back(ONES); exp_ct.push_back(ZERO); exp_ct.push_back(ONES);
    pts = {ZERO, ZERO, ZERO};
    run_job(MODE_OFB, 3, ZERO, 64'd0, 1'b1, 1'b0);

    // OFB, maximum block count
    pts = {};
    for (int b = 0; b < 7; b++) begin
      exp_cs.push_back((b % 2) ? ONES : ZERO);
      exp_ct.push_back((b % 2) ? ZERO : ONES);
      pts.push_back(ZERO);
    end
    run_job(MODE_OFB, 7, ZERO, 64'd0, 1'b0, 1'b0);

`ifdef AES_SEQ_CTR_EN
    exp_cs.push_back({NONCE, 64'd0}); exp_cs.push_back({NONCE, 64'd1});
    exp_ct.push_back({64'h5A5A5A5A5A5A5A5A, 64'hFFFFFFFFFFFFFFFF});
    exp_ct.push_back({64'h5A5A5A5A5A5A5A5A, 64'hFFFFFFFFFFFFFFFE});
    pts = {ZERO, ZERO};
    run_job(MODE_CTR, 2, ONES, NONCE, 1'b0, 1'b0);
`else
    issue(MODE_CTR, 2, ZERO, NONCE);
    exp_err++;
    @(negedge clk);
    chk("ctr_off_err", err_o, 1'b1);
    chk("ctr_off_busy", busy_o, 1'b0);
    tick();
`endif

    // nblocks = 0
    issue(MODE_CFB, 0, ZERO, 64'd0);
    exp_done++;
    @(negedge clk);
    chk("zero_blk_done", done_o, 1'b1);
    chk("zero_blk_busy", busy_o, 1'b0);
    @(negedge clk);
    chk("zero_blk_done_drop", done_o, 1'b0);
    tick();

    // reserved mode
    issue(MODE_RSVD, 3, ZERO, 64'd0);
    exp_err++;
    @(negedge clk);
    chk("rsvd_err", err_o, 1'b1);
    chk("rsvd_busy", busy_o, 1'b0);
    repeat (2) @(negedge clk);
    chk("rsvd_err_drop", err_o, 1'b0);
    chk("rsvd_busy_later", busy_o, 1'b0);
    chk("rsvd_no_core", cs_cnt, exp_cs_cnt);
    tick();

    // reset in the middle of CORE
    exp_cs.push_back(ZERO);
    issue(MODE_CFB, 2, ZERO, 64'd0);
    feed(ZERO);
    exp_cs_cnt++;
    repeat (5) tick();
    chk("mid_busy", busy_o, 1'b1);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy_o, 1'b0);
    chk("mid_rst_pt_ready", bus.pt_ready, 1'b0);
    chk("mid_rst_ct_valid", bus.ct_valid, 1'b0);
    chk("mid_rst_core_start", bus.core_start, 1'b0);
    chk("mid_rst_ct_data", bus.ct_data, ZERO);
    chk("mid_rst_core_state", bus.core_state, ZERO);
    exp_ct.delete();
    exp_cs.delete();
    tick();
    reset = 1'b0;
    repeat (20) tick();
    chk("post_rst_done", done_cnt, exp_done);
    chk("post_rst_err", err_cnt, exp_err);
    chk("post_rst_busy", busy_o, 1'b0);

    exp_cs.push_back(IV_A);  exp_cs.push_back(CT_A0);
    exp_ct.push_back(CT_A0); exp_ct.push_back(CT_A1);
    pts = {PT_A0, PT_A1};
    run_job(MODE_CFB, 2, IV_A, 64'd0, 1'b0, 1'b0);

    repeat (5) tick();
    chk("final_err_count", err_cnt, exp_err);
    chk("final_done_count", done_cnt, exp_done);
    chk("final_cs_left", exp_cs.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/aes_mode_sequencer.md
AES_MODE_SEQUENCER -- requirements
Module: aes_mode_sequencer

Interface
REQ-001 Parameter NBLK_W, default 3: width of the block-count input; up to 2^NBLK_W-1 blocks per job.
REQ-002 clk  in  1  clock; all state changes on rising edge.
REQ-003 reset  in  1  reset, asynchronous, active-high.
REQ-004 start  in  1  job request; sampled only in IDLE.
REQ-005 mode  in  2  0=CFB, 1=OFB, 2=CTR, 3=reserved; captured at accepted start.
REQ-006 nblocks  in  NBLK_W  blocks in the job; captured at accepted start.
REQ-007 iv  in  128  initial feedback for CFB/OFB; captured at accepted start.
REQ-008 nonce  in  64  CTR upper half; captured at accepted start.
REQ-009 pt_valid / pt_ready / pt_data  in / out / in  1 / 1 / 128  plaintext block handshake.
REQ-010 ct_valid / ct_ready / ct_data  out / in / out  1 / 1 / 128  ciphertext block handshake.
REQ-011 core_start  out  1  one-cycle pulse launching one AES-256 block operation on the external core.
REQ-012 core_state  out  128  core input block; held stable from core_start until core_done.
REQ-013 core_done / core_out  in / in  1 / 128  core completion pulse and keystream block.
REQ-014 busy  out  1  high in any state except IDLE.
REQ-015 done / err  out / out  1 / 1  one-cycle job-complete pulse / one-cycle rejected-job pulse.

Function
REQ-016 FSM states SHALL be IDLE, LOAD, CORE, OUT and FIN.
- IDLE→LOAD on start with legal mode and nblocks≠0.
- LOAD→CORE on pt_valid&pt_ready.
- CORE→OUT on core_done.
- OUT→LOAD on ct_valid&ct_ready with blocks remaining, else OUT→FIN.
- FIN→IDLE unconditionally.
REQ-017 pt_ready SHALL be high only in LOAD; the accepted pt_data SHALL be registered.
REQ-018 core_start SHALL pulse exactly on the first cycle in CORE.
REQ-019 core_done SHALL be ignored outside CORE.
REQ-020 In CORE the block SHALL register core_out; on the following cycle ct_valid=1 and ct_data=pt^core_out in every mode, held until ct_ready.
REQ-021 Feedback update at core_done:
- CFB: next core_state = pt^core_out.
- OFB: next core_state = core_out.
- CTR: core_state = {nonce, ctr}; the 64-bit ctr starts at 0, increments by 1 per block, and wraps modulo 2^64.
REQ-022 At accepted start, core_state SHALL load iv (CFB/OFB) or {nonce, 64'd0} (CTR).
REQ-023 done SHALL pulse for one cycle in FIN; busy SHALL drop on the cycle IDLE is re-entered.
REQ-024 start with nblocks=0 SHALL produce a done pulse on the next cycle, with no core_start and no handshakes.
REQ-025 start with mode=3 SHALL produce an err pulse on the next cycle, with no other activity; the FSM SHALL stay in IDLE.
REQ-026 start while busy SHALL be ignored; mode, nblocks, iv and nonce SHALL NOT change mid-job.
REQ-027 Minimum per-block latency SHALL be 1 (LOAD) + core latency + 1 (register) cycles from pt acceptance to ct_valid.

Reset
REQ-028 Reset SHALL force IDLE, clear the feedback register, ctr and block counter, and drive pt_ready, ct_valid, core_start, busy, done and err to 0 and ct_data and core_state to 0.
REQ-029 Reset asserted mid-job SHALL abort the job; no done or err pulse SHALL follow deassertion.

Configuration
REQ-030 Macro AES_SEQ_CTR_EN: when defined, CTR mode (mode=2) SHALL be fully supported; when undefined, the ctr register and nonce path SHALL be removed and mode=2 SHALL be treated as reserved (err pulse per REQ-025).

Structure
REQ-031 Package aes_seq_pkg SHALL hold the mode encodings (MODE_CFB/OFB/CTR/RSVD), the FSM state encoding and the block width constant (128).
REQ-032 No sub-module: FSM, feedback register and counters SHALL live in one module; the AES-256 core is instantiated by the parent.

Verification
Test benches use a stub core with core_out = ~core_state and a 14-cycle latency.
REQ-033 CFB, iv=0, nblocks=2, pt0=pt1=0 → ct0=all-ones, ct1=0, one done pulse, two core_start pulses.
REQ-034 OFB, iv=0, nblocks=3, pt=0 → ct = all-ones, 0, all-ones.
REQ-035 CTR, nonce=64'hA5A5..., nblocks=2, pt=0 → core_state {nonce,0} then {nonce,1}; ct0=~{nonce,0}.
REQ-036 ct_ready held low 10 cycles in OUT → ct_valid/ct_data stable, no new core_start; mode=3 → err pulse, busy stays 0; nblocks=0 → done next cycle.
REQ-037 Reset pulsed mid-CORE → all outputs 0 on reset; a new CFB job then completes correctly; a start pulsed while busy → no effect.
